// File: rtl/multiplexed_7segment_display_driver.sv
// Time-multiplexed 7-segment driver: scans DIGITS digits with a per-digit PWM
// window after a dead time, leading-zero blanking, blink and a per-frame snapshot.
module multiplexed_7segment_display_driver #(
  parameter int DIGITS              = 6,
  parameter int CLK_RATE_HZ         = 100_000_000,
  parameter int REFRESH_RATE_HZ     = 1000,
  parameter int DEAD_CYCLES         = 2,
  parameter int BRIGHTNESS_BITS     = 4,
  parameter int BLINK_FRAMES        = 256,
  parameter bit SEGMENTS_ACTIVE_LOW = 1'b0,
  parameter bit ENABLES_ACTIVE_LOW  = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [4*DIGITS-1:0]        data,
  input  logic [DIGITS-1:0]          digit_enable_mask,
  input  logic [DIGITS-1:0]          decimal_point_enable_mask,
  input  logic [DIGITS-1:0]          blink_mask,
  input  logic                       leading_zero_blank,
  input  logic [BRIGHTNESS_BITS-1:0] brightness,
  output logic [7:0]                 display_led_segments,
  output logic [DIGITS-1:0]          display_led_enable_mask,
  output logic                       frame_start
);

  localparam int SLOT_CYCLES = CLK_RATE_HZ / (REFRESH_RATE_HZ * DIGITS);
  localparam int C_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int O_W = C_W + 1;
  localparam int P_W = O_W + BRIGHTNESS_BITS + 1;
  localparam int D_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int B_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [7:0]        SEG_OFF = {8{SEGMENTS_ACTIVE_LOW}};
  localparam logic [DIGITS-1:0] EN_OFF  = {DIGITS{ENABLES_ACTIVE_LOW}};

  if (DIGITS < 1 || DIGITS > 16) begin : g_bad_digits
    $error("DIGITS must be in 1..16");
  end
  if (SLOT_CYCLES < DEAD_CYCLES + (1 << BRIGHTNESS_BITS)) begin : g_slot_too_short
    $error("slot too short for dead time plus full brightness range");
  end

  function automatic logic [6:0] seg_code(input logic [3:0] nib);
    case (nib)
      4'h0: seg_code = 7'h3F;  4'h1: seg_code = 7'h06;
      4'h2: seg_code = 7'h5B;  4'h3: seg_code = 7'h4F;
      4'h4: seg_code = 7'h66;  4'h5: seg_code = 7'h6D;
      4'h6: seg_code = 7'h7D;  4'h7: seg_code = 7'h07;
      4'h8: seg_code = 7'h7F;  4'h9: seg_code = 7'h6F;
      4'hA: seg_code = 7'h77;  4'hB: seg_code = 7'h7C;
      4'hC: seg_code = 7'h39;  4'hD: seg_code = 7'h5E;
      4'hE: seg_code = 7'h79;  default: seg_code = 7'h71;
    endcase
  endfunction

  // Full-width product so the top brightness code reaches the whole active span.
  function automatic logic [O_W-1:0] on_cycles(input logic [BRIGHTNESS_BITS-1:0] b);
    logic [P_W-1:0] prod;
    prod = P_W'(SLOT_CYCLES - DEAD_CYCLES) * (P_W'(b) + P_W'(1));
    on_cycles = O_W'(prod >> BRIGHTNESS_BITS);
  endfunction

  logic [C_W-1:0]             c_q, c_d;
  logic [D_W-1:0]             d_q, d_d;
  logic [B_W-1:0]             blink_cnt_q, blink_cnt_d;
  logic                       blink_phase_q, blink_phase_d;
  logic [4*DIGITS-1:0]        data_s_q, data_s_d;
  logic [DIGITS-1:0]          den_s_q, den_s_d;
  logic [DIGITS-1:0]          dp_s_q, dp_s_d;
  logic [DIGITS-1:0]          blink_s_q, blink_s_d;
  logic                       lzb_s_q, lzb_s_d;
  logic [BRIGHTNESS_BITS-1:0] bright_s_q, bright_s_d;
  logic                       phase_s_q, phase_s_d;
  logic [7:0]                 seg_q, seg_d;
  logic [DIGITS-1:0]          en_q, en_d;
  logic                       frame_start_q, frame_start_d;

  logic              frame_cond;
  logic              dark;
  logic              in_window;
  logic              zero_tail;
  logic [DIGITS-1:0] blanked;
  logic [3:0]        nibble;
  logic [7:0]        seg_raw;
  logic [DIGITS-1:0] en_raw;
  logic [O_W-1:0]    c_ext;

  assign frame_cond = (c_q == '0) && (d_q == '0);

  // Scan counters, blink counter and snapshot; the *_d snapshot values are the
  // frame's view, so digit 0 already sees inputs captured on the same edge.
  always_comb begin
    c_d = c_q + C_W'(1);
    d_d = d_q;
    if (c_q == C_W'(SLOT_CYCLES - 1)) begin
      c_d = '0;
      d_d = (d_q == D_W'(DIGITS - 1)) ? '0 : d_q + D_W'(1);
    end
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_cond) begin
      if (blink_cnt_q == B_W'(BLINK_FRAMES - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + B_W'(1);
      end
    end
    data_s_d   = frame_cond ? data                      : data_s_q;
    den_s_d    = frame_cond ? digit_enable_mask         : den_s_q;
    dp_s_d     = frame_cond ? decimal_point_enable_mask : dp_s_q;
    blink_s_d  = frame_cond ? blink_mask                : blink_s_q;
    lzb_s_d    = frame_cond ? leading_zero_blank        : lzb_s_q;
    bright_s_d = frame_cond ? brightness                : bright_s_q;
    phase_s_d  = frame_cond ? blink_phase_q             : phase_s_q;
  end

  always_comb begin
    zero_tail = 1'b1;
    blanked   = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_tail  = zero_tail && (data_s_d[4*k +: 4] == 4'h0);
      blanked[k] = zero_tail && lzb_s_d;
    end
    nibble    = data_s_d[4*d_q +: 4];
    dark      = !den_s_d[d_q] || (blink_s_d[d_q] && phase_s_d);
    c_ext     = {1'b0, c_q};
    in_window = (c_ext >= O_W'(DEAD_CYCLES)) &&
                (c_ext < O_W'(DEAD_CYCLES) + on_cycles(bright_s_d));
    seg_raw = 8'h00;
    if (!dark) seg_raw = {dp_s_d[d_q], blanked[d_q] ? 7'h00 : seg_code(nibble)};
    // Segments only reload at slot start, inside the dead time.
    seg_d        = (c_q == '0) ? (seg_raw ^ SEG_OFF) : seg_q;
    en_raw       = '0;
    en_raw[d_q]  = !dark && in_window;
    en_d         = en_raw ^ EN_OFF;
    frame_start_d = frame_cond;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_q           <= '0;
      d_q           <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      data_s_q      <= '0;
      den_s_q       <= '0;
      dp_s_q        <= '0;
      blink_s_q     <= '0;
      lzb_s_q       <= 1'b0;
      bright_s_q    <= '0;
      phase_s_q     <= 1'b0;
      seg_q         <= SEG_OFF;
      en_q          <= EN_OFF;
      frame_start_q <= 1'b0;
    end else begin
      c_q           <= c_d;
      d_q           <= d_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      data_s_q      <= data_s_d;
      den_s_q       <= den_s_d;
      dp_s_q        <= dp_s_d;
      blink_s_q     <= blink_s_d;
      lzb_s_q       <= lzb_s_d;
      bright_s_q    <= bright_s_d;
      phase_s_q     <= phase_s_d;
      seg_q         <= seg_d;
      en_q          <= en_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign display_led_segments    = seg_q;
  assign display_led_enable_mask = en_q;
  assign frame_start             = frame_start_q;

endmodule

// File: tb/tb_multiplexed_7segment_display_driver.sv
// Scoreboard bench: a frame-level reference model queues the expected look of
// every digit slot; a monitor rebuilds each slot from the pins and compares.
module tb_multiplexed_7segment_display_driver;

  localparam int DIGITS = 6;
  localparam int CLK_HZ = 96000;
  localparam int REF_HZ = 1000;
  localparam int DEAD   = 2;
  localparam int BB     = 2;
  localparam int BLINK  = 4;
  localparam int SLOT   = CLK_HZ / (REF_HZ * DIGITS);
  localparam int FRAME  = SLOT * DIGITS;
  localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
    7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic          clk = 1'b0;
  logic          rst_n;
  logic [23:0]   data;
  logic [5:0]    den, dpm, blm;
  logic          lzb;
  logic [1:0]    bright;
  logic [7:0]    seg;
  logic [5:0]    en;
  logic          fs;

  int checks = 0;
  int errors = 0;
  int slots_checked = 0;

  typedef struct {
    logic [7:0] seg;
    int         on;
    int         first;
  } slot_t;
  slot_t exp_q[$];

  multiplexed_7segment_display_driver #(
    .DIGITS(DIGITS), .CLK_RATE_HZ(CLK_HZ), .REFRESH_RATE_HZ(REF_HZ),
    .DEAD_CYCLES(DEAD), .BRIGHTNESS_BITS(BB), .BLINK_FRAMES(BLINK),
    .SEGMENTS_ACTIVE_LOW(1'b0), .ENABLES_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .reset(rst_n), .data(data), .digit_enable_mask(den),
    .decimal_point_enable_mask(dpm), .blink_mask(blm),
    .leading_zero_blank(lzb), .brightness(bright),
    .display_led_segments(seg), .display_led_enable_mask(en), .frame_start(fs)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Expected appearance of every digit of frame f, from the inputs at its start.
  task automatic push_frame(input int f);
    bit    phase;
    bit    dark, blank;
    slot_t s;
    logic [3:0] nib;
    phase = ((f / BLINK) % 2) == 1;
    for (int i = 0; i < DIGITS; i++) begin
      nib   = data[4*i +: 4];
      blank = lzb && (i >= 1) && ((data >> (4*i)) == 24'h0);
      dark  = !den[i] || (blm[i] && phase);
      s.seg   = dark ? 8'h00 : {dpm[i], blank ? 7'h00 : SEG_TAB[nib]};
      s.on    = dark ? 0 : ((SLOT - DEAD) * (int'(bright) + 1)) >> BB;
      s.first = (s.on > 0) ? DEAD : -1;
      exp_q.push_back(s);
    end
  endtask

  initial begin : model
    int n;
    n = 0;
    forever begin
      @(posedge clk);
      if (!rst_n) n = 0;
      else begin
        if (n % FRAME == 0) push_frame(n / FRAME);
        n++;
      end
    end
  end

  initial begin : monitor
    bit         synced, glitch;
    int         t, c, dd, cnt, first;
    logic [7:0] sseg;
    slot_t      e;
    synced = 0; t = 0; cnt = 0; first = -1; glitch = 0; sseg = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) synced = 0;
      else begin
        if (fs) begin
          if (synced) check("frame_period", t, FRAME);
          synced = 1;
          t = 0;
        end
        if (synced && t >= FRAME) begin
          check("frame_start_missing", 32'(fs), 1);
          synced = 0;
        end
        if (synced) begin
          c  = t % SLOT;
          dd = t / SLOT;
          if (c == 0) begin
            sseg = seg; cnt = 0; first = -1; glitch = 0;
          end else if (seg !== sseg) glitch = 1;
          for (int j = 0; j < DIGITS; j++) begin
            if (en[j]) begin
              if (j == dd) begin
                cnt++;
                if (first < 0) first = c;
              end else glitch = 1;
            end
          end
          if (c == SLOT - 1) begin
            if (exp_q.size() == 0) check("scoreboard_empty", exp_q.size(), 1);
            else begin
              e = exp_q.pop_front();
              check($sformatf("seg_d%0d", dd), 32'(sseg), 32'(e.seg));
              check($sformatf("on_cycles_d%0d", dd), cnt, e.on);
              check($sformatf("first_on_d%0d", dd), first, e.first);
              check($sformatf("stray_or_glitch_d%0d", dd), 32'(glitch), 0);
              slots_checked++;
            end
          end
          t++;
        end
      end
    end
  end

  task automatic run_frames(input int k);
    repeat (k * FRAME) @(negedge clk);
  endtask

  initial begin : stim
    int waited;
    rst_n = 1'b0; data = '0; den = '0; dpm = '0; blm = '0; lzb = 1'b0; bright = '0;
    repeat (3) @(negedge clk);
    check("reset_seg", 32'(seg), 0);
    check("reset_en", 32'(en), 0);
    check("reset_fs", 32'(fs), 0);

    // Basic scan
    data = 24'h123456; den = 6'b111111; dpm = 6'b010101; bright = 2'd3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("first_frame_start", 32'(fs), 1);
    run_frames(4);

    bright = 2'd0;
    run_frames(2);

    data = 24'h000070; lzb = 1'b1; bright = 2'd3; dpm = 6'b000000;
    run_frames(2);

    data = 24'h123456; lzb = 1'b0; blm = 6'b000001; den = 6'b111101; dpm = 6'b010101;
    run_frames(10);

    // Random inputs changing at arbitrary points inside frames
    for (int i = 0; i < 12 * FRAME; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) begin
        data   = 24'($urandom()) >> (4 * $urandom_range(0, 5));
        den    = 6'($urandom()) | 6'($urandom());
        dpm    = 6'($urandom());
        blm    = 6'($urandom()) & 6'($urandom());
        lzb    = 1'($urandom());
        bright = 2'($urandom());
      end
    end

    // Reset in the middle of a lit slot
    data = 24'h888888; den = 6'b111111; blm = 6'b000000; bright = 2'd3; dpm = 6'b111111;
    run_frames(1);
    waited = 0;
    while (en == 6'b0 && waited < 2 * SLOT) begin
      @(negedge clk);
      waited++;
    end
    check("enable_lit_before_reset", 32'(en != 6'b0), 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("midslot_reset_seg", 32'(seg), 0);
    check("midslot_reset_en", 32'(en), 0);
    check("midslot_reset_fs", 32'(fs), 0);
    repeat (3) @(negedge clk);
    data = 24'h0A5C3F; lzb = 1'b1; dpm = 6'b100001;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("restart_frame_start", 32'(fs), 1);
    run_frames(3);

    check("slots_checked_enough", 32'(slots_checked >= 150), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
